// File: rtl/keypad_pkg.sv
// Shared types and defaults for the keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StPressed,
    StLocked
  } key_state_e;

  localparam logic [15:0] KEY_NONE = 16'h0000;

  localparam int unsigned SCAN_DIV_DEFAULT        = 250000;
  localparam int unsigned DEBOUNCE_FRAMES_DEFAULT = 4;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'b0000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [3:0] key_index(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Column slot timer: one tick every SCAN_DIV cycles, advancing a 2-bit column index.
module scan_tick_gen
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic       o_tick,
  output logic [1:0] o_col_idx
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_idx;

  assign o_tick    = (r_cnt == CntW'(SCAN_DIV - 1));
  assign o_col_idx = r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (o_tick) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 keypad scanner with frame debounce and single/multi-key FSM.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = SCAN_DIV_DEFAULT,
  parameter int unsigned DEBOUNCE_FRAMES = DEBOUNCE_FRAMES_DEFAULT,
  parameter int unsigned REPEAT_FRAMES   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam logic [3:0] StableMax = 4'(DEBOUNCE_FRAMES - 1);

  logic        w_tick;
  logic [1:0]  w_col_idx;
  logic [3:0]  r_sync1, r_sync2;
  logic [15:0] r_snap, r_prev, w_frame;
  logic [3:0]  r_stable_cnt, w_stable_d;
  logic        w_frame_end, w_accept, w_single;
  logic [3:0]  w_idx;

  key_state_e  r_state, w_state_d;
  logic [3:0]  r_key_code, w_code_d;
  logic        r_key_valid, w_valid_d;
  logic        r_key_held;

  scan_tick_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .o_tick   (w_tick),
    .o_col_idx(w_col_idx)
  );

  assign col_out = ~(4'b0001 << w_col_idx);

  // Synchronizer resets to the released (pulled-up) row level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 4'hF;
      r_sync2 <= 4'hF;
    end else begin
      r_sync1 <= row_in;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_frame = r_snap;
    w_frame[{w_col_idx, 2'b00} +: 4] = ~r_sync2;
  end

  always_comb begin
    w_stable_d = '0;
    if (w_frame == r_prev) begin
      w_stable_d = (r_stable_cnt == StableMax) ? r_stable_cnt : r_stable_cnt + 4'd1;
    end
  end

  assign w_frame_end = w_tick && (w_col_idx == 2'd3);
  assign w_accept    = w_frame_end && (w_stable_d == StableMax);
  assign w_single    = (popcount16(w_frame) == 5'd1);
  assign w_idx       = key_index(w_frame);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap       <= KEY_NONE;
      r_prev       <= KEY_NONE;
      r_stable_cnt <= '0;
    end else if (w_tick) begin
      r_snap <= w_frame;
      if (w_frame_end) begin
        r_prev       <= w_frame;
        r_stable_cnt <= w_stable_d;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RepW = $clog2(REPEAT_FRAMES + 1);

  logic [RepW-1:0] r_rep_cnt, w_rep_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rep_cnt <= '0;
    else        r_rep_cnt <= w_rep_d;
  end
`else
  logic w_unused_repeat;
  assign w_unused_repeat = ^REPEAT_FRAMES;
`endif

  always_comb begin
    w_state_d = r_state;
    w_valid_d = 1'b0;
    w_code_d  = r_key_code;
`ifdef KEYPAD_REPEAT_EN
    w_rep_d   = r_rep_cnt;
`endif
    if (w_accept) begin
      unique case (r_state)
        StIdle: begin
          if (w_single) begin
            w_state_d = StPressed;
            w_code_d  = w_idx;
            w_valid_d = 1'b1;
`ifdef KEYPAD_REPEAT_EN
            w_rep_d   = '0;
`endif
          end else if (w_frame != KEY_NONE) begin
            w_state_d = StLocked;
          end
        end
        StPressed: begin
          if (w_frame == KEY_NONE) begin
            w_state_d = StIdle;
          end else if (w_single && (w_idx == r_key_code)) begin
`ifdef KEYPAD_REPEAT_EN
            if (r_rep_cnt == RepW'(REPEAT_FRAMES - 1)) begin
              w_valid_d = 1'b1;
              w_rep_d   = '0;
            end else begin
              w_rep_d = r_rep_cnt + 1'b1;
            end
`endif
          end else begin
            w_state_d = StLocked;
          end
        end
        StLocked: begin
          if (w_frame == KEY_NONE) w_state_d = StIdle;
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_key_code  <= '0;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_d;
      r_key_code  <= w_code_d;
      r_key_valid <= w_valid_d;
      r_key_held  <= (w_state_d == StPressed);
    end
  end

  assign key_code  = r_key_code;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed self-checking bench for keypad_scan; a behavioural keypad drives row_in from col_out.
module tb_keypad_scan;

  localparam int unsigned ScanDiv  = 8;
  localparam int unsigned Deb      = 4;
  localparam int unsigned Rep      = 3;
  localparam int unsigned FrameCyc = 4 * ScanDiv;
`ifdef KEYPAD_REPEAT_EN
  localparam bit RepEn = 1'b1;
`else
  localparam bit RepEn = 1'b0;
`endif

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] keys = 16'h0000;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_valid = 0;
  int base    = 0;

  keypad_scan #(
    .SCAN_DIV       (ScanDiv),
    .DEBOUNCE_FRAMES(Deb),
    .REPEAT_FRAMES  (Rep)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row_in   (row_in),
    .col_out  (col_out),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  initial forever #5 clk = ~clk;

  // Pressed key at (col, row) pulls that row low while its column is driven.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (col_out[c] == 1'b0) row_in = row_in & ~keys[c*4 +: 4];
    end
  end

  always @(negedge clk) begin
    if (rst_n && key_valid === 1'b1) n_valid <= n_valid + 1;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FrameCyc) @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_col", 16'(col_out), 16'hE);
    chk("rst_code", 16'(key_code), 16'h0);
    chk("rst_valid", 16'(key_valid), 16'h0);
    chk("rst_held", 16'(key_held), 16'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic exp_v;
    // Reset takes effect before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    chk("por_col", 16'(col_out), 16'hE);
    chk("por_code", 16'(key_code), 16'h0);
    chk("por_valid", 16'(key_valid), 16'h0);
    chk("por_held", 16'(key_held), 16'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Idle rows: column walk and no events
    #1;
    chk("walk_c0", 16'(col_out), 16'hE);
    repeat (ScanDiv) @(negedge clk);
    chk("walk_c1", 16'(col_out), 16'hD);
    repeat (ScanDiv) @(negedge clk);
    chk("walk_c2", 16'(col_out), 16'hB);
    repeat (ScanDiv) @(negedge clk);
    chk("walk_c3", 16'(col_out), 16'h7);
    repeat (ScanDiv) @(negedge clk);
    chk("walk_wrap", 16'(col_out), 16'hE);
    frames(5);
    chk("idle_nvalid", 16'(n_valid), 16'h0);
    chk("idle_held", 16'(key_held), 16'h0);

    // Key 6 held for 6 frames, then released
    do_reset();
    keys = 16'h0040;
    base = n_valid;
    frames(3);
    chk("k6_f3_valid", 16'(key_valid), 16'h0);
    chk("k6_f3_held", 16'(key_held), 16'h0);
    frames(1);
    chk("k6_f4_valid", 16'(key_valid), 16'h1);
    chk("k6_f4_code", 16'(key_code), 16'h6);
    chk("k6_f4_held", 16'(key_held), 16'h1);
    frames(2);
    chk("k6_count", 16'(n_valid - base), 16'h1);
    chk("k6_f6_held", 16'(key_held), 16'h1);
    keys = 16'h0000;
    frames(3);
    chk("k6_rel3_held", 16'(key_held), 16'h1);
    frames(1);
    chk("k6_rel4_held", 16'(key_held), 16'h0);
    chk("k6_rel_count", 16'(n_valid - base), 16'h1);
    chk("k6_rel_code", 16'(key_code), 16'h6);

    // Bounce key 6 on alternate frames, then stable
    do_reset();
    base = n_valid;
    for (int f = 1; f <= 10; f++) begin
      keys = (f % 2 == 1) ? 16'h0040 : 16'h0000;
      frames(1);
      chk("bounce_valid", 16'(key_valid), 16'h0);
    end
    keys = 16'h0040;
    frames(3);
    chk("bounce_s3_count", 16'(n_valid - base), 16'h0);
    frames(1);
    chk("bounce_s4_valid", 16'(key_valid), 16'h1);
    chk("bounce_s4_code", 16'(key_code), 16'h6);

    // Keys 0 and 15 together lock; dropping to one key stays locked
    do_reset();
    base = n_valid;
    keys = 16'h8001;
    frames(6);
    chk("multi_count", 16'(n_valid - base), 16'h0);
    chk("multi_held", 16'(key_held), 16'h0);
    keys = 16'h0001;
    frames(6);
    chk("locked_count", 16'(n_valid - base), 16'h0);
    chk("locked_held", 16'(key_held), 16'h0);
    keys = 16'h0000;
    frames(4);
    keys = 16'h8000;
    frames(3);
    chk("unlock_f3_valid", 16'(key_valid), 16'h0);
    frames(1);
    chk("unlock_f4_valid", 16'(key_valid), 16'h1);
    chk("unlock_f4_code", 16'(key_code), 16'hF);
    chk("unlock_f4_held", 16'(key_held), 16'h1);

    // Reset during the frame before acceptance discards the debounce
    do_reset();
    keys = 16'h0040;
    frames(3);
    repeat (10) @(negedge clk);
    base = n_valid;
    do_reset();
    frames(3);
    chk("midrst_f3_count", 16'(n_valid - base), 16'h0);
    frames(1);
    chk("midrst_f4_valid", 16'(key_valid), 16'h1);
    chk("midrst_f4_code", 16'(key_code), 16'h6);

    // Key 9 held for 12 frames: single pulse, or repeats every Rep frames
    do_reset();
    keys = 16'h0200;
    base = n_valid;
    for (int f = 1; f <= 12; f++) begin
      frames(1);
      exp_v = (f == 4) || (RepEn && f > 4 && ((f - 4) % Rep == 0));
      chk("hold9_valid", 16'(key_valid), 16'(exp_v));
      if (f >= 4) chk("hold9_code", 16'(key_code), 16'h9);
    end
    chk("hold9_count", 16'(n_valid - base), RepEn ? 16'h3 : 16'h1);

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
